// File: rtl/dmem_arbiter_pkg.sv
// dmem_arbiter_pkg: shared FSM encoding, default sizes and index-width helper
package dmem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int def_reg_width  = 12;
    localparam int def_addr_width = 12;
    localparam int def_core_count = 2;

    // width of a core index; a single bit is kept even for degenerate counts
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: per-core request bus plus the single-port RAM port
interface dmem_arbiter_if #(
    parameter int reg_width  = 12,
    parameter int addr_width = 12,
    parameter int core_count = 2
);
    logic [core_count-1:0]            req;
    logic [core_count-1:0]            we;
    logic [addr_width*core_count-1:0] addr;
    logic [reg_width*core_count-1:0]  wdata;
    logic [core_count-1:0]            ack;
    logic [reg_width*core_count-1:0]  rdata;
    logic [core_count-1:0]            grant;
    logic                             busy;
    logic [addr_width-1:0]            mem_addr;
    logic [reg_width-1:0]             mem_wdata;
    logic                             mem_wren;
    logic [reg_width-1:0]             mem_q;

    modport slave (
        input  req, we, addr, wdata, mem_q,
        output ack, rdata, grant, busy, mem_addr, mem_wdata, mem_wren
    );

    modport master (
        output req, we, addr, wdata, mem_q,
        input  ack, rdata, grant, busy, mem_addr, mem_wdata, mem_wren
    );
endinterface

// File: rtl/dmem_arbiter_rr_picker.sv
// rr_picker: first requesting core scanning upward from rr_ptr, wrapping
module rr_picker import dmem_arbiter_pkg::*; #(
    parameter  int core_count = def_core_count,
    localparam int iw         = idx_width(core_count)
) (
    input  logic [core_count-1:0] req,
    input  logic [iw-1:0]         rr_ptr,
    output logic                  found,
    output logic [iw-1:0]         idx
);
    // walk offsets from farthest to nearest so the nearest requester is written last
    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int k = core_count - 1; k >= 0; k--) begin
            if (req[(int'(rr_ptr) + k) % core_count]) begin
                found = 1'b1;
                idx   = iw'((int'(rr_ptr) + k) % core_count);
            end
        end
    end
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin sharing of one single-port data RAM among cores
module dmem_arbiter import dmem_arbiter_pkg::*; #(
    parameter int reg_width  = def_reg_width,
    parameter int addr_width = def_addr_width,
    parameter int core_count = def_core_count
) (
    input logic           clk,
    input logic           reset,
    dmem_arbiter_if.slave bus
);
    localparam int              iw       = idx_width(core_count);
    localparam logic [iw-1:0]   last_idx = iw'(core_count - 1);

    state_t                          state;
    logic [iw-1:0]                   sel;
    logic [iw-1:0]                   rr_ptr;
    logic [iw-1:0]                   pick;
    logic                            found;
    logic                            wren_q;
    logic                            busy_q;
    logic [core_count-1:0]           ack_q;
    logic [core_count-1:0]           grant_q;
    logic [reg_width*core_count-1:0] rdata_q;

    rr_picker #(.core_count(core_count)) u_rr_picker (
        .req   (bus.req),
        .rr_ptr(rr_ptr),
        .found (found),
        .idx   (pick)
    );

    // transaction sequencer; grant, busy, ack and write enable are registered alongside the state
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            sel     <= '0;
            rr_ptr  <= '0;
            wren_q  <= 1'b0;
            busy_q  <= 1'b0;
            ack_q   <= '0;
            grant_q <= '0;
        end else begin
            case (state)
                IDLE: if (found) begin
                    state   <= ISSUE;
                    sel     <= pick;
                    grant_q <= core_count'(1) << pick;
                    busy_q  <= 1'b1;
                    wren_q  <= bus.we[pick];
                end
                ISSUE: begin
                    state  <= wren_q ? DONE : WAIT;
                    ack_q  <= wren_q ? grant_q : '0;
                    wren_q <= 1'b0;
                end
                WAIT: begin
                    state <= DONE;
                    ack_q <= grant_q;
                end
                DONE: begin
                    state   <= IDLE;
                    ack_q   <= '0;
                    grant_q <= '0;
                    busy_q  <= 1'b0;
                    rr_ptr  <= (sel == last_idx) ? '0 : sel + 1'b1;
                end
            endcase
        end
    end

    // RAM data is valid in WAIT and lands in the owner's slice only
    always_ff @(posedge clk) begin
        if (reset) rdata_q <= '0;
        else if (state == WAIT) rdata_q[sel*reg_width +: reg_width] <= bus.mem_q;
    end

    assign bus.ack       = reset ? '0 : ack_q;
    assign bus.grant     = reset ? '0 : grant_q;
    assign bus.busy      = busy_q & ~reset;
    assign bus.mem_wren  = wren_q & ~reset;
    assign bus.mem_addr  = bus.addr[sel*addr_width +: addr_width];
    assign bus.mem_wdata = bus.wdata[sel*reg_width +: reg_width];
    assign bus.rdata     = rdata_q;
endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter reg_width, default 12: data word width.
REQ-002 Parameter addr_width, default 12: data memory address width.
REQ-003 Parameter core_count, default 2: number of requesting cores, at least 2.
REQ-004 clk  input  1: the single clock; all state updates on its rising edge.
REQ-005 reset  input  1: synchronous, active-high reset.
REQ-006 req  input  core_count: per-core request; bit i is held high, with stable operands, until ack[i].
REQ-007 we  input  core_count: per-core write flag, 1 = write, 0 = read.
REQ-008 addr  input  addr_width*core_count: flat per-core address; core j occupies slice [(j+1)*addr_width-1 -: addr_width].
REQ-009 wdata  input  reg_width*core_count: flat per-core write data; same slicing rule.
REQ-010 ack  output  core_count: one-cycle completion pulse per core.
REQ-011 rdata  output  reg_width*core_count: flat per-core registered read data.
REQ-012 grant  output  core_count: one-hot owner of the memory; all zero in IDLE.
REQ-013 busy  output  1: high in any state other than IDLE.
REQ-014 mem_addr  output  addr_width: address to the single-port data RAM.
REQ-015 mem_wdata  output  reg_width: write data to the RAM.
REQ-016 mem_wren  output  1: RAM write enable.
REQ-017 mem_q  input  reg_width: RAM read data, valid one cycle after the address is presented.

Function
REQ-018 The arbiter SHALL implement the FSM IDLE -> ISSUE -> (WAIT on a read) -> DONE -> IDLE.
REQ-019 In IDLE with any req bit high, it SHALL select the winner and enter ISSUE; with no req bit high, it SHALL remain in IDLE.
REQ-020 Winner selection: the first set req bit scanning upward from rr_ptr, wrapping modulo core_count.
REQ-021 The winner index sel SHALL be registered on entry to ISSUE and held until IDLE.
REQ-022 In ISSUE, mem_addr and mem_wdata SHALL carry the sel slices, and mem_wren SHALL equal we[sel].
REQ-023 Outside ISSUE, mem_wren SHALL be 0; mem_addr and mem_wdata SHALL hold the sel slices.
REQ-024 ISSUE SHALL go to DONE for a write and to WAIT for a read.
REQ-025 In WAIT, the sel slice of rdata SHALL load mem_q at the clock edge; the next state is DONE.
REQ-026 In DONE, ack[sel] SHALL be 1 for exactly one cycle, rr_ptr SHALL become (sel+1) mod core_count, and the next state is IDLE.
REQ-027 Latency from IDLE with req high to ack: 3 cycles for a write, 4 cycles for a read.
REQ-028 The rdata slice of a core SHALL hold its value until that core's next completed read; writes SHALL NOT change rdata.
REQ-029 A requester SHALL drop req on the edge at which it samples ack, so the IDLE cycle that follows never re-serves it.
REQ-030 Changes on non-selected req bits during ISSUE, WAIT or DONE SHALL be ignored until the next IDLE.
REQ-031 With all cores requesting continuously, service SHALL rotate 0, 1, ..., core_count-1, 0, ...; no core waits more than core_count transactions.
REQ-032 grant SHALL equal onehot(sel) in ISSUE, WAIT and DONE.

Reset
REQ-033 With reset high at an edge: state = IDLE, rr_ptr = 0, sel = 0, every rdata slice = 0.
REQ-034 While reset is high, mem_wren SHALL be forced to 0 combinationally, so an in-flight write is aborted.
REQ-035 While reset is high, ack, grant and busy SHALL all be 0; an interrupted transaction produces no ack.

Structure
REQ-036 A shared package SHALL hold the FSM state encoding (IDLE=0, ISSUE=1, WAIT=2, DONE=3) and the slicing helper constants.
REQ-037 Round-robin selection SHALL be a combinational sub-module rr_picker (inputs req and rr_ptr; outputs a found flag and the index), instantiated once.

Verification
REQ-038 Single write: core 0 writes addr 0x005, wdata 0xABC -> mem_wren high only in cycle 1, ack[0] in cycle 2, then a read of 0x005 returns 0xABC.
REQ-039 Single read: core 1 reads 0x005 -> ack[1] in cycle 3, rdata slice 1 = 0xABC, rdata slice 0 unchanged.
REQ-040 Simultaneous: cores 0 and 1 both read at reset-time rr_ptr = 0 -> core 0 is acked first, core 1 next, and rr_ptr ends at 0.
REQ-041 Fairness: both cores request continuously for 8 transactions -> grants alternate 0,1,0,1,...; each core is acked 4 times.
REQ-042 Reset in ISSUE of a write -> mem_wren is 0 that cycle, RAM content is unchanged, no ack, and the block returns to IDLE with busy 0.
REQ-043 Wrap: core_count=4, rr_ptr=3, req=0b1001 -> core 3 is served, then core 0.
